inv_mixcol_seq: RTL and testbench

INV_MIXCOL_SEQ -- requirements
Module: inv_mixcol_seq

---
 rtl/inv_mixcol_seq_if.sv | 30 +++
 rtl/inv_mixcol_seq.sv | 113 +++++++++++
 tb/tb_inv_mixcol_seq.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_mixcol_seq_if.sv
// Stream interface for inv_mixcol_seq: input state handshake and result handshake.
// Carries key_i only when INV_MIXCOL_SEQ_ARK_EN is defined.
interface inv_mixcol_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] state_i;
  logic         skip_i;
`ifdef INV_MIXCOL_SEQ_ARK_EN
  logic [0:127] key_i;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [0:127] result_o;

  modport master (
    output in_valid, state_i, skip_i, out_ready,
`ifdef INV_MIXCOL_SEQ_ARK_EN
    output key_i,
`endif
    input  in_ready, out_valid, result_o
  );

  modport slave (
    input  in_valid, state_i, skip_i, out_ready,
`ifdef INV_MIXCOL_SEQ_ARK_EN
    input  key_i,
`endif
    output in_ready, out_valid, result_o
  );
endinterface

// File: rtl/inv_mixcol_seq.sv
// Column-serial AES InvMixColumns: one shared 32-bit engine, four RUN cycles per block.
// Optional INV_MIXCOL_SEQ_ARK_EN applies AddRoundKey to each column before the engine.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | processing column col (0..3), one per cycle
// DONE  | result valid, waiting for out_ready
module inv_mixcol_seq (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  output logic            busy_o,
  inv_mixcol_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_q;
  logic [0:127] cap_state_q;
  logic [0:127] result_q;
  logic         skip_q;
  logic         accept;
  logic [0:31]  col_in, col_out;
`ifdef INV_MIXCOL_SEQ_ARK_EN
  logic [0:127] cap_key_q;
`endif

  // Constant multiply in GF(2^8)/0x11B; k is a 4-bit multiplier built from xtime powers.
  function automatic logic [7:0] gmul(input logic [7:0] v, input logic [3:0] k);
    logic [7:0] m2, m4, m8;
    m2 = {v[6:0], 1'b0}  ^ (v[7]  ? 8'h1b : 8'h00);
    m4 = {m2[6:0], 1'b0} ^ (m2[7] ? 8'h1b : 8'h00);
    m8 = {m4[6:0], 1'b0} ^ (m4[7] ? 8'h1b : 8'h00);
    return (k[0] ? v : 8'h00) ^ (k[1] ? m2 : 8'h00) ^
           (k[2] ? m4 : 8'h00) ^ (k[3] ? m8 : 8'h00);
  endfunction

  function automatic logic [0:31] inv_mix_col(input logic [0:31] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[0:7];
    a1 = c[8:15];
    a2 = c[16:23];
    a3 = c[24:31];
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd) ^ gmul(a0, 4'h9),
            gmul(a2, 4'he) ^ gmul(a3, 4'hb) ^ gmul(a0, 4'hd) ^ gmul(a1, 4'h9),
            gmul(a3, 4'he) ^ gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9)};
  endfunction

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = RUN;
        RUN:     if (col_q == 2'd3) state_d = DONE;
        DONE:    if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !flush_i;
    bus.out_valid = (state_q == DONE);
    busy_o        = (state_q != IDLE);
  end

  always_comb begin
    col_in = cap_state_q[{col_q, 5'b0} +: 32];
`ifdef INV_MIXCOL_SEQ_ARK_EN
    col_in = col_in ^ cap_key_q[{col_q, 5'b0} +: 32];
`endif
    col_out = skip_q ? col_in : inv_mix_col(col_in);
  end

  // Result columns are only written in RUN, so result_o holds steady through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= 2'd0;
      cap_state_q <= '0;
      result_q    <= '0;
      skip_q      <= 1'b0;
`ifdef INV_MIXCOL_SEQ_ARK_EN
      cap_key_q   <= '0;
`endif
    end else if (flush_i) begin
      col_q <= 2'd0;
    end else if (accept) begin
      col_q       <= 2'd0;
      cap_state_q <= bus.state_i;
      skip_q      <= bus.skip_i;
`ifdef INV_MIXCOL_SEQ_ARK_EN
      cap_key_q   <= bus.key_i;
`endif
    end else if (state_q == RUN) begin
      result_q[{col_q, 5'b0} +: 32] <= col_out;
      col_q <= col_q + 2'd1;
    end
  end

  assign bus.result_o = result_q;

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Self-checking bench for inv_mixcol_seq: directed vectors, random blocks against a
// GF(2^8) reference model, backpressure, flush and asynchronous reset.
module tb_inv_mixcol_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  inv_mixcol_seq_if bus();

  inv_mixcol_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .busy_o  (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference: shift-and-add field multiply, then the InvMixColumns matrix per column.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [0:127] ref_model(input logic [0:127] st, input bit sk,
                                             input logic [0:127] ky);
    logic [0:127] r;
    logic [7:0]   a [4];
    logic [7:0]   coef [4];
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
`ifdef INV_MIXCOL_SEQ_ARK_EN
    st = st ^ ky;
`else
    ky = '0;
    st = st ^ ky;
`endif
    r = st;
    if (!sk) begin
      for (int c = 0; c < 4; c++) begin
        for (int i = 0; i < 4; i++) a[i] = st[32*c + 8*i +: 8];
        for (int i = 0; i < 4; i++) begin
          logic [7:0] acc = 8'h00;
          for (int j = 0; j < 4; j++) acc = acc ^ ref_mul(coef[j], a[(i + j) % 4]);
          r[32*c + 8*i +: 8] = acc;
        end
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic [0:127] st, input bit sk, input logic [0:127] ky);
    bus.state_i = st;
    bus.skip_i  = sk;
`ifdef INV_MIXCOL_SEQ_ARK_EN
    bus.key_i   = ky;
`else
    if (ky != ky) bus.skip_i = sk;
`endif
  endtask

  // Drives one block and returns the result, edges from handshake to out_valid, and timeout flag.
  task automatic do_block(input logic [0:127] st, input bit sk, input logic [0:127] ky,
                          output logic [0:127] res, output int lat, output bit to);
    int n = 0;
    to  = 1'b0;
    lat = 0;
    res = '0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    if (!bus.in_ready) begin to = 1'b1; return; end
    drive_in(st, sk, ky);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin tick(); lat++; end
    if (!bus.out_valid) begin to = 1'b1; return; end
    res = bus.result_o;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bus.result_o !== 128'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result_o); end
    #5 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    logic [0:127] st [2];
    logic [0:127] ex [2];
    logic [0:127] res;
    int lat;
    bit to;
    st[0] = {4{32'h8e4da1bc}};
    ex[0] = {4{32'hdb135345}};
    st[1] = {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h8e4da1bc};
    ex[1] = {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hdb135345};
    for (int v = 0; v < 2; v++) begin
      do_block(st[v], 1'b0, '0, res, lat, to);
      checks++; if (to) begin errors++; $display("FAIL vec%0d_timeout got timeout want completion", v); end
      checks++; if (res !== ex[v]) begin errors++; $display("FAIL vec%0d_result got %h want %h", v, res, ex[v]); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL vec%0d_latency got %0d want 4", v, lat); end
    end
  endtask

  task automatic test_skip();
    logic [0:127] st, ky, res, ex;
    int lat;
    bit to;
    st = {$urandom, $urandom, $urandom, $urandom};
    ky = '1;
`ifdef INV_MIXCOL_SEQ_ARK_EN
    ex = ~st;
`else
    ex = st;
`endif
    do_block(st, 1'b1, ky, res, lat, to);
    checks++; if (to) begin errors++; $display("FAIL skip_timeout got timeout want completion"); end
    checks++; if (res !== ex) begin errors++; $display("FAIL skip_result got %h want %h", res, ex); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL skip_latency got %0d want 4", lat); end
  endtask

  task automatic test_random();
    logic [0:127] st, ky, res, ex;
    int lat;
    bit to, sk;
    for (int n = 0; n < 20; n++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      ky = {$urandom, $urandom, $urandom, $urandom};
      sk = ($urandom_range(0, 3) == 0);
      ex = ref_model(st, sk, ky);
      do_block(st, sk, ky, res, lat, to);
      checks++; if (to || res !== ex || lat !== 4)
        begin errors++; $display("FAIL random%0d got %h lat %0d want %h lat 4", n, res, lat, ex); end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:127] st, res;
    int lat;
    bit to;
    for (int n = 0; n < 3; n++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      do_block(st, 1'b0, '0, res, lat, to);
      checks++; if (to || res !== ref_model(st, 1'b0, '0))
        begin errors++; $display("FAIL b2b%0d_result got %h want %h", n, res, ref_model(st, 1'b0, '0)); end
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
        begin errors++; $display("FAIL b2b%0d_after_ack got valid %b ready %b want 0 1", n, bus.out_valid, bus.in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [0:127] st, held;
    int lat = 0;
    bit bad_valid = 0, bad_stable = 0, bad_ready = 0;
    st = {$urandom, $urandom, $urandom, $urandom};
    drive_in(st, 1'b0, '0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin tick(); lat++; end
    held = bus.result_o;
    checks++; if (held !== ref_model(st, 1'b0, '0))
      begin errors++; $display("FAIL bp_result got %h want %h", held, ref_model(st, 1'b0, '0)); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin drive_in(~st, 1'b1, '0); bus.in_valid = 1'b1; end
      if (i == 4) bus.in_valid = 1'b0;
      if (bus.out_valid !== 1'b1) bad_valid = 1;
      if (bus.result_o !== held) bad_stable = 1;
      if (bus.in_ready !== 1'b0) bad_ready = 1;
      tick();
    end
    checks++; if (bad_valid) begin errors++; $display("FAIL bp_valid got drop want held 1"); end
    checks++; if (bad_stable) begin errors++; $display("FAIL bp_stable got change want %h", held); end
    checks++; if (bad_ready) begin errors++; $display("FAIL bp_in_ready got 1 want 0"); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_no_accept got busy %b valid %b want 0 0", busy, bus.out_valid); end
  endtask

  task automatic test_flush();
    logic [0:127] st, res;
    int lat;
    bit to, seen = 0;
    st = {$urandom, $urandom, $urandom, $urandom};
    drive_in(st, 1'b0, '0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready_during got %b want 0", bus.in_ready); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL flush_idle got ready %b busy %b want 1 0", bus.in_ready, busy); end
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen = 1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_no_valid got out_valid 1 want 0"); end
    st = {$urandom, $urandom, $urandom, $urandom};
    do_block(st, 1'b0, '0, res, lat, to);
    checks++; if (to || res !== ref_model(st, 1'b0, '0) || lat !== 4)
      begin errors++; $display("FAIL flush_next got %h lat %0d want %h lat 4", res, lat, ref_model(st, 1'b0, '0)); end
  endtask

  task automatic test_async_reset();
    logic [0:127] st, res;
    int lat;
    bit to;
    st = {$urandom, $urandom, $urandom, $urandom};
    drive_in(st, 1'b0, '0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL areset_ctrl got busy %b valid %b ready %b want 0 0 1", busy, bus.out_valid, bus.in_ready); end
    checks++; if (bus.result_o !== 128'h0) begin errors++; $display("FAIL areset_result got %h want 0", bus.result_o); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL areset_release got %b want 1", bus.in_ready); end
    st = {$urandom, $urandom, $urandom, $urandom};
    do_block(st, 1'b0, '0, res, lat, to);
    checks++; if (to || res !== ref_model(st, 1'b0, '0))
      begin errors++; $display("FAIL areset_next got %h want %h", res, ref_model(st, 1'b0, '0)); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_in('0, 1'b0, '0);
    test_reset();
    test_vectors();
    test_skip();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
